// File: rtl/arbitro_alu.sv
// arbitro_alu: two requesters (A, B) share one ALU through a round-robin
// grant, a one-cycle execute stage and a registered valid/ready response.
// unidad_logico_aritmetica is the shared combinational ALU.

// Combinational ALU. Shift codes move the selected operand by one bit; the
// carry flag returns the bit that falls off, the overflow flag is only
// meaningful for add, sub and arithmetic shift left.
module unidad_logico_aritmetica #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic [N-1:0] resultado,
  output logic         negativo,
  output logic         cero,
  output logic         overflow,
  output logic         carry
);

  logic [N:0] suma;

  // Operation decode; codes 1110/1111 fall to the default and yield zero.
  always_comb begin
    resultado = '0;
    overflow  = 1'b0;
    carry     = 1'b0;
    suma      = '0;
    case (control)
      4'b0000: resultado = a & b;
      4'b0001: resultado = a | b;
      4'b0010: resultado = a ^ b;
      4'b0011: resultado = ~a;
      4'b0100: begin
        resultado = a >> 1;
        carry     = a[0];
      end
      4'b0101: begin
        resultado = a << 1;
        carry     = a[N-1];
      end
      4'b0110: begin
        resultado = b >> 1;
        carry     = b[0];
      end
      4'b0111: begin
        resultado = b << 1;
        carry     = b[N-1];
      end
      4'b1000: begin
        suma      = {1'b0, a} + {1'b0, b};
        resultado = suma[N-1:0];
        carry     = suma[N];
        overflow  = (a[N-1] == b[N-1]) && (suma[N-1] != a[N-1]);
      end
      4'b1001: begin
        resultado = a - b;
        // carry means "no borrow"
        carry     = (a >= b);
        overflow  = (a[N-1] != b[N-1]) && (resultado[N-1] != a[N-1]);
      end
      4'b1010: begin
        resultado = $signed(a) >>> 1;
        carry     = a[0];
      end
      4'b1011: begin
        resultado = a << 1;
        carry     = a[N-1];
        overflow  = a[N-1] ^ a[N-2];
      end
      4'b1100: begin
        resultado = $signed(b) >>> 1;
        carry     = b[0];
      end
      4'b1101: begin
        resultado = b << 1;
        carry     = b[N-1];
        overflow  = b[N-1] ^ b[N-2];
      end
      default: resultado = '0;
    endcase
  end

  // Result-derived flags shared by every operation.
  always_comb begin
    negativo = resultado[N-1];
    cero     = (resultado == '0);
  end

endmodule

module arbitro_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valido,
  output logic         a_listo,
  input  logic [N-1:0] a_op1,
  input  logic [N-1:0] a_op2,
  input  logic [3:0]   a_control,
  input  logic         b_valido,
  output logic         b_listo,
  input  logic [N-1:0] b_op1,
  input  logic [N-1:0] b_op2,
  input  logic [3:0]   b_control,
  output logic         res_valido,
  input  logic         res_listo,
  output logic [N-1:0] res_dato,
  output logic         res_id,
  output logic [3:0]   res_flags,
  output logic         res_error,
  output logic         ocupado
);

  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    EJECUTA   = 2'd1,
    RESPUESTA = 2'd2
  } estado_t;

  typedef struct packed {
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic [3:0]   control;
    logic         id;
  } solicitud_t;

  estado_t    estado, estado_sig;
  solicitud_t cap, entrada;
  logic       puntero;   // 0: A wins a tie, 1: B wins a tie
  logic       sel_b;
  logic       acepta;
  logic       ilegal;

  logic [N-1:0] alu_res;
  logic         alu_neg, alu_cero, alu_ovf, alu_carry;

  // Grant choice: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    sel_b = (a_valido && b_valido) ? puntero : b_valido;
  end

  // Payload of the granted requester, tagged with its id.
  always_comb begin
    entrada = '0;
    if (sel_b) begin
      entrada.op1     = b_op1;
      entrada.op2     = b_op2;
      entrada.control = b_control;
      entrada.id      = 1'b1;
    end else begin
      entrada.op1     = a_op1;
      entrada.op2     = a_op2;
      entrada.control = a_control;
      entrada.id      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) estado <= LIBRE;
    else        estado <= estado_sig;
  end

  // Next state and handshake outputs; listo is held low while in reset.
  always_comb begin
    estado_sig = estado;
    a_listo    = 1'b0;
    b_listo    = 1'b0;
    acepta     = 1'b0;
    res_valido = 1'b0;
    ocupado    = (estado != LIBRE);
    case (estado)
      LIBRE: begin
        if (rst_n) begin
          a_listo = a_valido && !sel_b;
          b_listo = b_valido && sel_b;
          acepta  = (a_valido && !sel_b) || (b_valido && sel_b);
        end
        if (acepta) estado_sig = EJECUTA;
      end
      EJECUTA: estado_sig = RESPUESTA;
      RESPUESTA: begin
        res_valido = 1'b1;
        if (res_listo) estado_sig = LIBRE;
      end
      default: estado_sig = LIBRE;
    endcase
  end

  // Capture the granted request and hand the tie to the other requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap     <= '0;
      puntero <= 1'b0;
    end else if (acepta) begin
      cap     <= entrada;
      puntero <= ~entrada.id;
    end
  end

  // The ALU only ever sees the captured request, never the live inputs.
  unidad_logico_aritmetica #(.N(N)) u_alu (
    .a         (cap.op1),
    .b         (cap.op2),
    .control   (cap.control),
    .resultado (alu_res),
    .negativo  (alu_neg),
    .cero      (alu_cero),
    .overflow  (alu_ovf),
    .carry     (alu_carry)
  );

  always_comb begin
    ilegal = (cap.control[3:1] == 3'b111);
  end

  // Response register, loaded at the end of the execute cycle and then
  // frozen until the next execute, so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_dato  <= '0;
      res_flags <= '0;
      res_id    <= 1'b0;
      res_error <= 1'b0;
    end else if (estado == EJECUTA) begin
      res_id <= cap.id;
      if (ilegal) begin
        res_dato  <= '0;
        res_flags <= '0;
        res_error <= 1'b1;
      end else begin
        res_dato  <= alu_res;
        res_flags <= {alu_neg, alu_cero, alu_ovf, alu_carry};
        res_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_alu.sv
// Bench for arbitro_alu: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_arbitro_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valido, b_valido, res_listo;
  logic       a_listo, b_listo, res_valido, res_id, res_error, ocupado;
  logic [7:0] a_op1, a_op2, b_op1, b_op2, res_dato;
  logic [3:0] a_control, b_control, res_flags;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit         m_known = 0;
  bit         m_ptr, m_exec, m_rv, m_id, m_err, cid;
  logic [7:0] m_dato, c1, c2;
  logic [3:0] m_flags, cc;
  bit         ea, eb, acc_a, acc_b;
  int         ids[$];

  always #5 clk = ~clk;

  arbitro_alu #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valido(a_valido), .a_listo(a_listo), .a_op1(a_op1), .a_op2(a_op2), .a_control(a_control),
    .b_valido(b_valido), .b_listo(b_listo), .b_op1(b_op1), .b_op2(b_op2), .b_control(b_control),
    .res_valido(res_valido), .res_listo(res_listo), .res_dato(res_dato), .res_id(res_id),
    .res_flags(res_flags), .res_error(res_error), .ocupado(ocupado)
  );

  // Reference ALU from plain integer arithmetic: {error, flags, dato}.
  function automatic logic [12:0] ref_alu(input int a, input int b, input int c);
    int r, sa, sb, ss;
    bit cy, ov, er;
    r = 0; cy = 0; ov = 0; er = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (c)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: r = 255 - a;
      4: begin r = a / 2; cy = (a % 2) == 1; end
      5: begin r = (a * 2) % 256; cy = a >= 128; end
      6: begin r = b / 2; cy = (b % 2) == 1; end
      7: begin r = (b * 2) % 256; cy = b >= 128; end
      8: begin r = (a + b) % 256; cy = (a + b) > 255; ss = sa + sb; ov = (ss > 127) || (ss < -128); end
      9: begin r = (a - b + 256) % 256; cy = a >= b; ss = sa - sb; ov = (ss > 127) || (ss < -128); end
      10: begin r = a / 2 + ((a >= 128) ? 128 : 0); cy = (a % 2) == 1; end
      11: begin r = (a * 2) % 256; cy = a >= 128; ov = (a >= 128) != (r >= 128); end
      12: begin r = b / 2 + ((b >= 128) ? 128 : 0); cy = (b % 2) == 1; end
      13: begin r = (b * 2) % 256; cy = b >= 128; ov = (b >= 128) != (r >= 128); end
      default: er = 1;
    endcase
    if (er) return {1'b1, 4'b0000, 8'h00};
    return {1'b0, (r >= 128), (r == 0), ov, cy, 8'(r)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven at the falling edge; compare
  // outputs against the model, then advance the model across the rising edge.
  task automatic cyc();
    bit free, gb;
    #1;
    free = !m_exec && !m_rv && rst_n;
    gb   = (a_valido && b_valido) ? m_ptr : b_valido;
    ea   = free && a_valido && !gb;
    eb   = free && b_valido && gb;
    if (m_known) begin
      chk("a_listo", a_listo, ea);
      chk("b_listo", b_listo, eb);
      chk("listo_excl", a_listo && b_listo, 0);
      chk("res_valido", res_valido, m_rv);
      chk("ocupado", ocupado, m_exec || m_rv);
      chk("res_dato", res_dato, m_dato);
      chk("res_id", res_id, m_id);
      chk("res_flags", res_flags, m_flags);
      chk("res_error", res_error, m_err);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1; m_ptr = 0; m_exec = 0; m_rv = 0;
      m_dato = 0; m_flags = 0; m_id = 0; m_err = 0;
      c1 = 0; c2 = 0; cc = 0; cid = 0;
    end else begin
      if (m_rv && res_listo) m_rv = 0;
      if (m_exec) begin
        {m_err, m_flags, m_dato} = ref_alu(int'(c1), int'(c2), int'(cc));
        m_id = cid; m_exec = 0; m_rv = 1;
      end
      if (ea || eb) begin
        c1 = ea ? a_op1 : b_op1;
        c2 = ea ? a_op2 : b_op2;
        cc = ea ? a_control : b_control;
        cid = eb; m_exec = 1; m_ptr = !eb;
      end
    end
    acc_a = ea; acc_b = eb;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; a_valido = 0; b_valido = 0; res_listo = 0;
    a_op1 = 0; a_op2 = 0; a_control = 0; b_op1 = 0; b_op2 = 0; b_control = 0;
    @(negedge clk);
    cyc(); cyc();
    rst_n = 1;

    // single add: FF + 01
    a_valido = 1; a_op1 = 8'hFF; a_op2 = 8'h01; a_control = 4'b1000; res_listo = 1;
    cyc();
    a_valido = 0;
    cyc();
    #1;
    chk("add_valid", res_valido, 1);
    chk("add_dato", res_dato, 8'h00);
    chk("add_flags", res_flags, 4'b0101);
    chk("add_id", res_id, 0);
    chk("add_err", res_error, 0);
    cyc();

    // round-robin after a fresh reset
    rst_n = 0; cyc(); rst_n = 1;
    a_valido = 1; b_valido = 1;
    a_op1 = 8'($urandom); a_op2 = 8'($urandom); a_control = 4'($urandom_range(0, 13));
    b_op1 = 8'($urandom); b_op2 = 8'($urandom); b_control = 4'($urandom_range(0, 13));
    for (int k = 0; k < 40 && ids.size() < 4; k++) begin
      cyc();
      if (acc_a) begin a_op1 = 8'($urandom); a_op2 = 8'($urandom); end
      if (acc_b) begin b_op1 = 8'($urandom); b_op2 = 8'($urandom); end
      if (res_valido) ids.push_back(int'(res_id));
    end
    a_valido = 0; b_valido = 0;
    chk("rr_count", ids.size(), 4);
    for (int k = 0; k < 4 && k < ids.size(); k++) chk("rr_id", ids[k], k % 2);
    cyc();

    // backpressure: B AND held while A waits
    b_valido = 1; b_op1 = 8'hF0; b_op2 = 8'h3C; b_control = 4'b0000; res_listo = 0;
    cyc();
    b_valido = 0; a_valido = 1; a_op1 = 8'h21; a_op2 = 8'h13; a_control = 4'b0010;
    cyc();
    repeat (5) begin
      #1;
      chk("bp_valid", res_valido, 1);
      chk("bp_dato", res_dato, 8'h30);
      chk("bp_id", res_id, 1);
      chk("bp_a_listo", a_listo, 0);
      cyc();
    end
    res_listo = 1;
    cyc();
    #1;
    chk("bp_done", res_valido, 0);
    chk("bp_a_grant", a_listo, 1);
    cyc();
    a_valido = 0;
    cyc(); cyc();

    // illegal code, then a legal subtract
    a_valido = 1; a_op1 = 8'($urandom); a_op2 = 8'($urandom); a_control = 4'b1111;
    cyc();
    a_valido = 0;
    cyc();
    #1;
    chk("ill_err", res_error, 1);
    chk("ill_dato", res_dato, 0);
    chk("ill_flags", res_flags, 0);
    cyc();
    a_valido = 1; a_op1 = 8'h05; a_op2 = 8'h03; a_control = 4'b1001;
    cyc();
    a_valido = 0;
    cyc();
    #1;
    chk("sub_dato", res_dato, 8'h02);
    chk("sub_err", res_error, 0);
    chk("sub_flags", res_flags, 4'b0001);
    cyc();

    // payload wobbles while waiting; the value at the accept edge counts
    b_valido = 1; b_op1 = 8'($urandom); b_op2 = 8'($urandom); b_control = 4'b0001;
    cyc();
    b_valido = 0; res_listo = 0; a_valido = 1;
    repeat (4) begin
      a_op1 = 8'($urandom); a_op2 = 8'($urandom); a_control = 4'($urandom);
      cyc();
    end
    res_listo = 1; a_op1 = 8'h12; a_op2 = 8'h34; a_control = 4'b1000;
    cyc();
    cyc();
    a_valido = 0; a_op1 = 8'hAA; a_op2 = 8'h55; a_control = 4'b1111;
    cyc();
    #1;
    chk("stab_dato", res_dato, 8'h46);
    chk("stab_id", res_id, 0);
    cyc();

    // reset in the middle of execute
    b_valido = 1; b_op1 = 8'h7F; b_op2 = 8'h01; b_control = 4'b1000;
    cyc();
    b_valido = 0; rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    #1;
    chk("rst_valid", res_valido, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_dato", res_dato, 0);
    chk("rst_flags", res_flags, 0);
    chk("rst_err", res_error, 0);
    chk("rst_id", res_id, 0);
    a_valido = 1; b_valido = 1;
    #1;
    chk("rst_a_grant", a_listo, 1);
    chk("rst_b_wait", b_listo, 0);
    cyc();
    a_valido = 0; b_valido = 0;
    cyc(); cyc(); cyc();

    // randomized traffic
    repeat (3000) begin
      if (acc_a) a_valido = 0;
      if (acc_b) b_valido = 0;
      if (!a_valido && ($urandom % 3 == 0)) begin
        a_valido = 1; a_op1 = 8'($urandom); a_op2 = 8'($urandom); a_control = 4'($urandom);
      end
      if (!b_valido && ($urandom % 3 == 0)) begin
        b_valido = 1; b_op1 = 8'($urandom); b_op2 = 8'($urandom); b_control = 4'($urandom);
      end
      res_listo = ($urandom % 4) != 0;
      rst_n = ($urandom % 300) != 0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
